router_port_rx: RTL and testbench

- Serial-to-parallel receiver attached to one router output port (the far end of the per-port output mux).
- Watches the active-low frame/valid strobes and the serial data bit, and packs payload bits LSB-first into bytes.
- Presents each byte on a valid/ready byte interface, marking the last byte of the packet and flagging any partial trailing byte.
- Used as the packet sink in port-level verification and as the front end of downstream byte consumers.

---
 rtl/router_pkg.sv | 18 +
 rtl/rx_hold_reg.sv | 71 +++++++
 rtl/router_port_rx.sv | 135 +++++++++++++
 tb/tb_router_port_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port receiver.
package router_pkg;

  typedef enum logic {
    StIdle,
    StRecv
  } rx_state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;

  // Frame and valid strobes from the output port are active-low.
  localparam logic ASSERTED_N = 1'b0;

  function automatic logic is_asserted(input logic strobe_n);
    return strobe_n == ASSERTED_N;
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register; drops and flags a byte offered while full.
module rx_hold_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err,
  input  logic              out_ready,
  output logic              overflow
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              overflow_q, overflow_d;
  logic              load;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    err_d      = err_q;
    overflow_d = overflow_q;
    // A drain and a load in the same cycle keep the register full with no bubble.
    load       = in_valid && (!valid_q || out_ready);
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
      err_d   = in_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && !load) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_err   = err_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/router_port_rx.sv
// Serial receiver for one router output port: packs LSB-first payload bits into bytes.
module router_port_rx
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              din,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              byte_err,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              overflow
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              pkt_done_q;
  logic [LEN_W-1:0]  pkt_len_q;

  logic              sample;
  logic              last;
  logic              word_full;
  logic              partial;
  logic [CNT_W-1:0]  cnt_after;
  logic [DATA_W-1:0] assembled;
  logic              emit_valid;
  logic              emit_err;
  logic [LEN_W-1:0]  len_emit;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_asserted(frame_n)) begin
          state_d = StRecv;
          sample  = is_asserted(valid_n);
        end
      end
      StRecv: begin
        sample = is_asserted(valid_n);
        if (!is_asserted(frame_n)) begin
          last    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    assembled = shift_q;
    cnt_after = bit_cnt_q;
    word_full = sample && (bit_cnt_q == CNT_MAX);
    if (sample) begin
      assembled[bit_cnt_q] = din;
      cnt_after            = word_full ? '0 : bit_cnt_q + CNT_W'(1);
    end
    // Leftover bits at end of frame become a zero-padded partial byte.
    partial    = last && (cnt_after != '0);
    emit_valid = word_full || partial;
    emit_err   = partial;
    len_emit   = emit_valid ? sat_inc(len_q) : len_q;

    if (last) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      len_d     = '0;
    end else begin
      bit_cnt_d = cnt_after;
      shift_d   = word_full ? '0 : assembled;
      len_d     = len_emit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      // Registered so the pulse lines up with the final byte appearing.
      pkt_done_q <= last;
      if (last) begin
        pkt_len_q <= len_emit;
      end
    end
  end

  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;

  rx_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clock    (clock),
    .reset    (reset),
    .in_valid (emit_valid),
    .in_data  (assembled),
    .in_last  (last),
    .in_err   (emit_err),
    .out_valid(byte_valid),
    .out_data (byte_data),
    .out_last (byte_last),
    .out_err  (byte_err),
    .out_ready(byte_ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_router_port_rx.sv
// Directed self-checking bench for router_port_rx.
module tb_router_port_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_n;
  logic        valid_n;
  logic        din;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        byte_err;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        overflow;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    int         c;
  } byte_rec_t;

  byte_rec_t bq[$];
  int        dq[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_fail = 0;
  int        last_cyc;

  router_port_rx #(
    .DATA_W(8),
    .LEN_W (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .din       (din),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_last (byte_last),
    .byte_err  (byte_err),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Handshakes and done pulses are sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset && byte_valid && byte_ready) begin
      bq.push_back('{d: byte_data, l: byte_last, e: byte_err, c: cyc});
    end
    if (!reset && pkt_done) begin
      dq.push_back(int'(pkt_len));
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic fn, input logic vn, input logic d);
    frame_n = fn;
    valid_n = vn;
    din     = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0);
  endtask

  // Sends nbits of vec LSB-first; frame_n rises with the final bit.
  task automatic send_bits(input logic [31:0] vec, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (gap) drive(1'b0, 1'b1, 1'b0);
      drive((i == nbits - 1), 1'b0, vec[i]);
    end
    last_cyc = cyc;
  endtask

  task automatic clear_logs();
    bq.delete();
    dq.delete();
  endtask

  initial begin
    reset      = 1'b1;
    byte_ready = 1'b1;
    frame_n    = 1'b1;
    valid_n    = 1'b1;
    din        = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", 32'(byte_valid), 0);
    check_eq("rst_data", 32'(byte_data), 0);
    check_eq("rst_done", 32'(pkt_done), 0);
    check_eq("rst_len", 32'(pkt_len), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    idle(2);

    // Two full bytes.
    clear_logs();
    send_bits(32'h0000_3CA5, 16, 0);
    idle(4);
    check_eq("t1_nbytes", bq.size(), 2);
    if (bq.size() == 2) begin
      check_eq("t1_b0", 32'(bq[0].d), 'hA5);
      check_eq("t1_b0_last", 32'(bq[0].l), 0);
      check_eq("t1_b0_err", 32'(bq[0].e), 0);
      check_eq("t1_b1", 32'(bq[1].d), 'h3C);
      check_eq("t1_b1_last", 32'(bq[1].l), 1);
      check_eq("t1_b1_err", 32'(bq[1].e), 0);
    end
    check_eq("t1_ndone", dq.size(), 1);
    if (dq.size() == 1) check_eq("t1_len", dq[0], 2);

    // 11 bits: full byte then a 3-bit partial.
    clear_logs();
    send_bits(32'h0000_05FF, 11, 0);
    idle(4);
    check_eq("t2_nbytes", bq.size(), 2);
    if (bq.size() == 2) begin
      check_eq("t2_b0", 32'(bq[0].d), 'hFF);
      check_eq("t2_b0_err", 32'(bq[0].e), 0);
      check_eq("t2_b1", 32'(bq[1].d), 'h05);
      check_eq("t2_b1_last", 32'(bq[1].l), 1);
      check_eq("t2_b1_err", 32'(bq[1].e), 1);
    end
    check_eq("t2_ndone", dq.size(), 1);
    if (dq.size() == 1) check_eq("t2_len", dq[0], 2);

    // Consumer stalled for a 3-byte packet.
    clear_logs();
    byte_ready = 1'b0;
    send_bits(32'h0033_2211, 24, 0);
    idle(1);
    check_eq("t3_valid", 32'(byte_valid), 1);
    check_eq("t3_data", 32'(byte_data), 'h11);
    check_eq("t3_last", 32'(byte_last), 0);
    check_eq("t3_ovf", 32'(overflow), 1);
    idle(3);
    check_eq("t3_data_hold", 32'(byte_data), 'h11);
    check_eq("t3_ndone", dq.size(), 1);
    if (dq.size() == 1) check_eq("t3_len", dq[0], 3);
    byte_ready = 1'b1;
    idle(2);
    check_eq("t3_nbytes", bq.size(), 1);
    if (bq.size() == 1) check_eq("t3_b0", 32'(bq[0].d), 'h11);
    check_eq("t3_drained", 32'(byte_valid), 0);
    check_eq("t3_ovf_sticky", 32'(overflow), 1);

    // Two-cycle gaps between every bit.
    clear_logs();
    send_bits(32'h0000_0081, 8, 2);
    idle(4);
    check_eq("t4_nbytes", bq.size(), 1);
    if (bq.size() == 1) begin
      check_eq("t4_b0", 32'(bq[0].d), 'h81);
      check_eq("t4_latency", bq[0].c - last_cyc, 0);
    end

    // Reset mid-packet, then a clean packet.
    clear_logs();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check_eq("t5_ovf_clr", 32'(overflow), 0);
    idle(1);
    send_bits(32'h0000_005A, 8, 0);
    idle(4);
    check_eq("t5_nbytes", bq.size(), 1);
    if (bq.size() == 1) check_eq("t5_b0", 32'(bq[0].d), 'h5A);
    check_eq("t5_ndone", dq.size(), 1);
    if (dq.size() == 1) check_eq("t5_len", dq[0], 1);

    // Back-to-back packets, no idle between.
    clear_logs();
    send_bits(32'h0000_0012, 8, 0);
    send_bits(32'h0000_0034, 8, 0);
    idle(4);
    check_eq("t6_nbytes", bq.size(), 2);
    if (bq.size() == 2) begin
      check_eq("t6_b0", 32'(bq[0].d), 'h12);
      check_eq("t6_b0_last", 32'(bq[0].l), 1);
      check_eq("t6_b1", 32'(bq[1].d), 'h34);
      check_eq("t6_b1_last", 32'(bq[1].l), 1);
    end
    check_eq("t6_ndone", dq.size(), 2);
    if (dq.size() == 2) begin
      check_eq("t6_len0", dq[0], 1);
      check_eq("t6_len1", dq[1], 1);
    end

    // Empty packet.
    clear_logs();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    idle(3);
    check_eq("t7_nbytes", bq.size(), 0);
    check_eq("t7_ndone", dq.size(), 1);
    if (dq.size() == 1) check_eq("t7_len", dq[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
